rst_seq_ctrl: RTL and testbench

Reset sequencing controller that sits directly behind the chip-level reset synchronizer. It takes the synchronized active-low reset and releases per-subsystem reset lines one at a time, with programmable spacing between releases. It also accepts soft reset requests over a req/ack handshake, and runs a watchdog that re-enters the sequence on expiry. It records the cause of the most recent reset for firmware and debug readback.

---
 rtl/rst_seq_pkg.sv | 21 ++
 rtl/rst_seq_wdog.sv | 37 +++
 rtl/rst_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencing controller.
// Holds the FSM state enum, reset-cause codes and a width helper.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_SOFT = 2'b01;
    localparam logic [1:0] CAUSE_WDOG = 2'b10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rst_seq_wdog.sv
// Watchdog counter: counts edges while running with the watchdog enabled.
// Ports: clk, rst_n, run, wdog_en, wdog_kick in; expire (one-cycle) out.
module rst_seq_wdog #(
    parameter int WDOG_CYC = 1024,
    parameter int CW       = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic wdog_en,
    input  logic wdog_kick,
    output logic expire
);

    localparam logic [CW-1:0] LAST = CW'(WDOG_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A kick on the would-be expiry edge suppresses the expiry.
    assign expire = run & wdog_en & ~wdog_kick & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!run || !wdog_en || wdog_kick || expire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: releases stage resets one by one after reset, soft
// request or watchdog expiry. Ports: clk, rst_n, soft_req, wdog_en,
// wdog_kick in; stage_rst_n, all_ready, rst_ack, rst_cause out.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int HOLD_CYC   = 8,
    parameter int STAGE_DLY  = 16,
    parameter int WDOG_CYC   = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  soft_req,
    output logic                  rst_ack,
    input  logic                  wdog_en,
    input  logic                  wdog_kick,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  all_ready,
    output logic [1:0]            rst_cause
);

    localparam int CW = $clog2(max3(HOLD_CYC, STAGE_DLY, WDOG_CYC)) + 1;
    localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] DLY_LAST  = CW'(STAGE_DLY - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  ready_q, ready_d;
    logic                  ack_q, ack_d;
    logic [1:0]            cause_q, cause_d;
    logic                  soft_q;
    logic                  soft_edge;
    logic                  run;
    logic                  expire;

    assign run       = (state_q == RUN);
    assign soft_edge = soft_req & ~soft_q;

    rst_seq_wdog #(
        .WDOG_CYC (WDOG_CYC),
        .CW       (CW)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .wdog_en   (wdog_en),
        .wdog_kick (wdog_kick),
        .expire    (expire)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        ready_d = ready_q;
        ack_d   = 1'b0;
        cause_d = cause_q;
        unique case (state_q)
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d      = '0;
                    idx_d      = IW'(1);
                    stage_d[0] = 1'b1;
                    if (NUM_STAGES == 1) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == DLY_LAST) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + IW'(1);
                    stage_d = stage_q | (NUM_STAGES'(1) << idx_q);
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                // Expiry outranks a simultaneous soft request.
                if (expire || soft_edge) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    stage_d = '0;
                    ready_d = 1'b0;
                    cause_d = expire ? CAUSE_WDOG : CAUSE_SOFT;
                    ack_d   = ~expire;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
                stage_d = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
            cause_q <= CAUSE_POR;
            // Start high so a request held through reset is not an edge.
            soft_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            cause_q <= cause_d;
            soft_q  <= soft_req;
        end
    end

    assign stage_rst_n = stage_q;
    assign all_ready   = ready_q;
    assign rst_ack     = ack_q;
    assign rst_cause   = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl using an elapsed-time reference
// model of the release schedule, soft requests and watchdog.
module tb_rst_seq_ctrl;

    localparam int N    = 3;
    localparam int HC   = 8;
    localparam int SD   = 16;
    localparam int WD   = 1024;
    localparam int TRUN = HC + (N - 1) * SD;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         soft_req  = 1'b0;
    logic         wdog_en   = 1'b0;
    logic         wdog_kick = 1'b0;
    logic         rst_ack;
    logic [N-1:0] stage_rst_n;
    logic         all_ready;
    logic [1:0]   rst_cause;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: edge number, edge of the last reset event,
    // watchdog edges-in-run count, sticky cause, ack, soft level.
    int       n;
    int       start;
    int       wd;
    logic [1:0] cause_m;
    logic     ack_m;
    logic     soft_prev;

    rst_seq_ctrl #(
        .NUM_STAGES (N),
        .HOLD_CYC   (HC),
        .STAGE_DLY  (SD),
        .WDOG_CYC   (WD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .soft_req    (soft_req),
        .rst_ack     (rst_ack),
        .wdog_en     (wdog_en),
        .wdog_kick   (wdog_kick),
        .stage_rst_n (stage_rst_n),
        .all_ready   (all_ready),
        .rst_cause   (rst_cause)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] exp_stage();
        logic [N-1:0] s;
        for (int k = 0; k < N; k++) begin
            s[k] = ((n - start) >= HC + k * SD);
        end
        return s;
    endfunction

    function automatic logic exp_ready();
        return ((n - start) >= TRUN);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h",
                   tag, n, obs, exp);
        end
    endtask

    task automatic check_all();
        check("stage_rst_n", 32'(stage_rst_n), 32'(exp_stage()));
        check("all_ready", 32'(all_ready), 32'(exp_ready()));
        check("rst_ack", 32'(rst_ack), 32'(ack_m));
        check("rst_cause", 32'(rst_cause), 32'(cause_m));
    endtask

    task automatic model_reset();
        n         = 0;
        start     = 0;
        wd        = 0;
        cause_m   = 2'b00;
        ack_m     = 1'b0;
        soft_prev = 1'b1;
    endtask

    task automatic model_edge();
        logic run_prev;
        run_prev = ((n - start) >= TRUN);
        n++;
        ack_m = 1'b0;
        if (run_prev) begin
            if (wdog_en && !wdog_kick && wd == WD - 1) begin
                start   = n;
                cause_m = 2'b10;
                wd      = 0;
            end else if (soft_req && !soft_prev) begin
                start   = n;
                cause_m = 2'b01;
                ack_m   = 1'b1;
                wd      = 0;
            end else if (!wdog_en || wdog_kick) begin
                wd = 0;
            end else begin
                wd++;
            end
        end else begin
            wd = 0;
        end
        soft_prev = soft_req;
    endtask

    task automatic cyc(input logic s, input logic e, input logic k);
        soft_req  = s;
        wdog_en   = e;
        wdog_kick = k;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic por_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_running();
        for (int i = 0; i < 200 && (n - start) < TRUN; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
        end
        check("reach_run", 32'(all_ready), 32'd1);
    endtask

    initial begin
        logic hit;
        logic sl;
        logic el;
        model_reset();

        // POR release schedule.
        por_reset();
        repeat (45) cyc(1'b0, 1'b0, 1'b0);

        // Soft reset held high: one reset only.
        repeat (130) cyc(1'b1, 1'b0, 1'b0);
        check("soft_cause", 32'(rst_cause), 32'd1);
        repeat (5) cyc(1'b0, 1'b0, 1'b0);

        // Soft pulses during HOLD and RELEASE are ignored.
        cyc(1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (15) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (30) cyc(1'b0, 1'b0, 1'b0);

        // Watchdog expiry with no kicks.
        repeat (1100) cyc(1'b0, 1'b1, 1'b0);
        check("wdog_cause", 32'(rst_cause), 32'd2);

        // Regular kicks keep the system running.
        wait_running();
        for (int i = 0; i < 10000; i++) begin
            cyc(1'b0, 1'b1, (i % 1000) == 999);
        end
        check("kick_ready", 32'(all_ready), 32'd1);

        // Kick on the expiry edge wins; cause set to soft first.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        wait_running();
        hit = 1'b0;
        for (int i = 0; i < 1100 && !hit; i++) begin
            if (wd == WD - 1) begin
                cyc(1'b0, 1'b1, 1'b1);
                hit = 1'b1;
            end else begin
                cyc(1'b0, 1'b1, 1'b0);
            end
        end
        check("kick_edge_hit", 32'(hit), 32'd1);
        check("kick_edge_ready", 32'(all_ready), 32'd1);
        check("kick_edge_cause", 32'(rst_cause), 32'd1);

        // Soft edge and expiry on the same edge: watchdog wins.
        hit = 1'b0;
        for (int i = 0; i < 1100 && !hit; i++) begin
            if (wd == WD - 1) begin
                cyc(1'b1, 1'b1, 1'b0);
                hit = 1'b1;
            end else begin
                cyc(1'b0, 1'b1, 1'b0);
            end
        end
        check("both_hit", 32'(hit), 32'd1);
        check("both_cause", 32'(rst_cause), 32'd2);
        check("both_ack", 32'(rst_ack), 32'd0);
        cyc(1'b0, 1'b0, 1'b0);

        // Async reset mid-sequence, then full restart.
        por_reset();
        repeat (30) cyc(1'b0, 1'b0, 1'b0);
        check("mid_stage", 32'(stage_rst_n), 32'd3);
        por_reset();
        check("mid_rst_stage", 32'(stage_rst_n), 32'd0);
        repeat (45) cyc(1'b0, 1'b0, 1'b0);
        check("mid_cause", 32'(rst_cause), 32'd0);

        // Randomised soft/enable/kick traffic.
        sl = 1'b0;
        el = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) sl = ~sl;
            if ($urandom_range(0, 199) == 0) el = ~el;
            cyc(sl, el, $urandom_range(0, 699) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
